// File: rtl/spi_controller.sv
// spi_controller: single-frame SPI mode-0 controller sending {rw, addr[6:0], wdata[7:0]}
// MSB first. SCLK half-period is DIV clk cycles.
// Optional read capture is compiled in with `define SPI_CTRL_READBACK_EN; without it
// rdata is tied to 0x00 and cipo is ignored.
module spi_controller #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [2:0]  state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic        phase;     // 0 = SCLK low half, 1 = SCLK high half
  logic [15:0] shreg;
  logic        div_zero;

  assign div_zero = (div_cnt == '0);

  // Frame sequencer: state, half-period divider, bit counter and transmit shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {rw, addr, wdata};
            div_cnt <= DIV_LAST;
            bit_cnt <= '0;
            phase   <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_zero) begin
            div_cnt <= DIV_LAST;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (div_zero) begin
            div_cnt <= DIV_LAST;
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              // copi only advances on the falling edge, and not after the last bit
              if (bit_cnt == 5'd15) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                shreg   <= {shreg[14:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        HOLD: begin
          if (div_zero) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= DONE;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign ncs  = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign sclk = (state == SHIFT) && phase;
  assign copi = ncs ? 1'b0 : shreg[15];

`ifdef SPI_CTRL_READBACK_EN
  logic       rw_q;
  logic [7:0] rx;
  logic [7:0] rdata_q;

  // Read capture: sample cipo as SCLK rises for bits 8..15, publish whole byte entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q    <= 1'b0;
      rx      <= '0;
      rdata_q <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        rw_q <= rw;
      end
      if ((state == SHIFT) && div_zero && !phase && bit_cnt[3]) begin
        rx <= {rx[6:0], cipo};
      end
      if ((state == HOLD) && div_zero && !rw_q) begin
        rdata_q <= rx;
      end
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_cipo;
  assign unused_cipo = cipo;
  assign rdata       = '0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed, table-driven bench for spi_controller.
// DIV=4 instance for frame content/busy/done checks, DIV=2 instance for phase timing.
module tb_spi_controller;

`ifdef SPI_CTRL_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       cipo = 1'b0;
  logic       cipo2 = 1'b0;

  logic       busy, done, sclk, copi, ncs;
  logic [7:0] rdata;
  logic       busy2, done2, sclk2, copi2, ncs2;
  logic [7:0] rdata2;

  int n_cmp = 0;
  int n_err = 0;

  spi_controller #(.DIV(DIV_A)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .copi(copi),
    .ncs(ncs), .cipo(cipo)
  );

  spi_controller #(.DIV(DIV_B)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .sclk(sclk2), .copi(copi2),
    .ncs(ncs2), .cipo(cipo2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one frame on the DIV=4 instance, acting as the slave on cipo.
  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] w,
                           input logic [7:0] sb, input bit change_w,
                           output logic [15:0] frm, output int rises, output int bcyc,
                           output int dn, output logic [7:0] rd_at_done, output bit finished);
    logic prev_s;
    frm = '0; rises = 0; bcyc = 0; dn = 0; rd_at_done = '0; finished = 0; prev_s = 1'b0;
    cipo = 1'b0;
    @(negedge clk);
    rw = r; addr = a; wdata = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (busy) bcyc++;
      if (sclk && !prev_s) begin
        frm = {frm[14:0], copi};
        rises++;
      end
      if (done) begin
        dn++;
        rd_at_done = rdata;
      end
      prev_s = sclk;
      if (!busy) begin
        finished = 1;
        break;
      end
      cipo = (rises >= 8 && rises < 16) ? sb[15 - rises] : 1'b0;
      if (change_w && rises == 4) wdata = 8'hFF;
      @(negedge clk);
    end
    cipo = 1'b0;
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] slave;
    logic [15:0] exp_frame;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] frm;
    logic [7:0]  rd;
    int          rises, bcyc, dn;
    bit          fin;

    vecs[0] = '{1'b1, 7'h02, 8'hA5, 8'h00, 16'h82A5, 8'h00};
    vecs[1] = '{1'b0, 7'h04, 8'h00, 8'h3C, 16'h0400, RB ? 8'h3C : 8'h00};
    vecs[2] = '{1'b1, 7'h7F, 8'h00, 8'hFF, 16'hFF00, RB ? 8'h3C : 8'h00};
    vecs[3] = '{1'b0, 7'h00, 8'hFF, 8'hA5, 16'h00FF, RB ? 8'hA5 : 8'h00};
    vecs[4] = '{1'b1, 7'h55, 8'h5A, 8'h0F, 16'hD55A, RB ? 8'hA5 : 8'h00};

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ncs", ncs, 1);
    check("reset_sclk", sclk, 0);
    check("reset_copi", copi, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rdata", rdata, 8'h00);

    // table-driven frames on DIV=4
    foreach (vecs[i]) begin
      run_frame(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].slave, 1'b0,
                frm, rises, bcyc, dn, rd, fin);
      check($sformatf("v%0d_finished", i), fin, 1);
      check($sformatf("v%0d_frame", i), frm, vecs[i].exp_frame);
      check($sformatf("v%0d_rises", i), rises, 16);
      check($sformatf("v%0d_busy_cycles", i), bcyc, 34 * DIV_A + 1);
      check($sformatf("v%0d_done_pulses", i), dn, 1);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // wdata changed mid-frame must not affect the transmitted frame
    run_frame(1'b1, 7'h02, 8'hA5, 8'h00, 1'b1, frm, rises, bcyc, dn, rd, fin);
    check("wchg_finished", fin, 1);
    check("wchg_frame", frm, 16'h82A5);

    // start held high: two frames, one idle cycle between, no accept while busy
    begin
      int frames, gap, f2_cyc, dn2;
      bit gap_ncs_ok;
      logic prev_b;
      frames = 0; gap = 0; f2_cyc = 0; dn2 = 0; gap_ncs_ok = 1; prev_b = 1'b0;
      @(negedge clk);
      rw = 1'b1; addr = 7'h11; wdata = 8'h22; start = 1'b1;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (busy && !prev_b) begin
          frames++;
          f2_cyc = 0;
        end
        if (frames == 2) begin
          f2_cyc++;
          if (f2_cyc >= 50) start = 1'b0;
        end
        if (!busy && frames == 1) begin
          gap++;
          if (!ncs) gap_ncs_ok = 0;
        end
        if (done) dn2++;
        prev_b = busy;
      end
      start = 1'b0;
      check("held_frames", frames, 2);
      check("held_idle_gap", gap, 1);
      check("held_gap_ncs_high", gap_ncs_ok, 1);
      check("held_done_pulses", dn2, 2);
    end

    // reset at the 7th SCLK rising edge aborts the frame
    begin
      int r7, dn3, b3;
      logic prev_s;
      r7 = 0; dn3 = 0; b3 = 0; prev_s = 1'b0;
      @(negedge clk);
      rw = 1'b0; addr = 7'h04; wdata = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
        if (sclk && !prev_s) r7++;
        prev_s = sclk;
        if (r7 == 7) break;
        @(negedge clk);
      end
      check("rst_reached_edge7", r7, 7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_ncs", ncs, 1);
      check("rst_sclk", sclk, 0);
      check("rst_busy", busy, 0);
      check("rst_copi", copi, 0);
      check("rst_rdata", rdata, 8'h00);
      for (int c = 0; c < 200; c++) begin
        if (done) dn3++;
        if (busy) b3++;
        @(negedge clk);
      end
      check("rst_no_done", dn3, 0);
      check("rst_stays_idle", b3, 0);
    end

    // DIV=2 phase timing
    begin
      int rises2, b2, t_ncs_fall, t_ncs_rise, t_first_rise, t_last_fall, t_last_edge;
      int hi_min, hi_max, lo_min, lo_max;
      logic prev_s, prev_n;
      logic [15:0] frm2;
      rises2 = 0; b2 = 0; t_ncs_fall = -100; t_ncs_rise = -100; t_first_rise = 0;
      t_last_fall = 0; t_last_edge = 0; hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
      prev_s = 1'b0; prev_n = 1'b1; frm2 = '0;
      @(negedge clk);
      rw = 1'b1; addr = 7'h2A; wdata = 8'hC3; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (busy2) b2++;
        if (!ncs2 && prev_n) t_ncs_fall = t;
        if (ncs2 && !prev_n) t_ncs_rise = t;
        if (sclk2 && !prev_s) begin
          rises2++;
          frm2 = {frm2[14:0], copi2};
          if (rises2 == 1) begin
            t_first_rise = t;
          end else begin
            if (t - t_last_edge < lo_min) lo_min = t - t_last_edge;
            if (t - t_last_edge > lo_max) lo_max = t - t_last_edge;
          end
          t_last_edge = t;
        end
        if (!sclk2 && prev_s) begin
          if (t - t_last_edge < hi_min) hi_min = t - t_last_edge;
          if (t - t_last_edge > hi_max) hi_max = t - t_last_edge;
          t_last_edge = t;
          t_last_fall = t;
        end
        prev_s = sclk2;
        prev_n = ncs2;
        @(negedge clk);
      end
      check("div2_rises", rises2, 16);
      check("div2_frame", frm2, 16'hAAC3);
      check("div2_busy_cycles", b2, 34 * DIV_B + 1);
      check("div2_high_min", hi_min, 2);
      check("div2_high_max", hi_max, 2);
      check("div2_low_min", lo_min, 2);
      check("div2_low_max", lo_max, 2);
      check("div2_ncs_to_first_rise", t_first_rise - t_ncs_fall, 4);
      check("div2_last_fall_to_ncs_high", t_ncs_rise - t_last_fall, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter DIV, default 4, number of clk cycles per SCLK half-period; legal values 2..255.
REQ-002 SHALL have exactly one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-006 SHALL have port rw, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, 7 bits: register address.
REQ-008 SHALL have port wdata, input, 8 bits: write data.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 8 bits: data captured during the last read.
REQ-012 SHALL have port sclk, output, 1 bit: SPI clock, mode 0 (idles low).
REQ-013 SHALL have port copi, output, 1 bit: controller-out serial data.
REQ-014 SHALL have port ncs, output, 1 bit: active-low chip select.
REQ-015 SHALL have port cipo, input, 1 bit: controller-in serial data, already synchronous to clk.

Function
REQ-016 SHALL implement the states IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-017 SHALL, in IDLE with start=1, latch {rw, addr, wdata} into a 16-bit shift register and go to SETUP; inputs SHALL be ignored after this.
REQ-018 SHALL send frames MSB first: bit15 = rw, bits14:8 = addr, bits7:0 = wdata; a read SHALL send wdata unchanged.
REQ-019 SHALL drive ncs=0 and copi=bit15 on entering SETUP, and stay in SETUP for DIV cycles with sclk=0.
REQ-020 SHALL, in SHIFT, produce 16 SCLK periods, each DIV cycles low followed by DIV cycles high.
REQ-021 SHALL change copi only at the high-to-low SCLK transition, moving to the next bit, so copi is stable across every rising edge.
REQ-022 SHALL, after the 16th high phase, drive sclk=0 and enter HOLD for DIV cycles with ncs still 0.
REQ-023 SHALL, leaving HOLD, drive ncs=1 and enter DONE, where done=1 for exactly one cycle; the next cycle SHALL be IDLE.
REQ-024 SHALL assert busy for exactly 34*DIV + 1 cycles per transaction: SETUP + SHIFT + HOLD + DONE.
REQ-025 SHALL ignore start while busy; a start held high in DONE SHALL NOT be accepted until IDLE.
REQ-026 SHALL accept a start in the first IDLE cycle after DONE, giving back-to-back frames with 1 idle cycle of ncs high.
REQ-027 SHALL use a divider counter that counts DIV-1 down to 0 and reloads, and a 5-bit bit counter; neither SHALL wrap within a frame.
REQ-028 SHALL drive copi=0 when ncs=1.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, force IDLE with sclk=0, ncs=1, copi=0, busy=0, done=0, rdata=0x00, and clear all counters.
REQ-030 SHALL, on reset during a transaction, abort it: ncs=1 on the next cycle, no done pulse, rdata unchanged from 0x00.
REQ-031 SHALL give rst priority over start in the same cycle.

Configuration
REQ-032 SHALL use macro SPI_CTRL_READBACK_EN to compile in read capture.
REQ-033 SHALL, with SPI_CTRL_READBACK_EN defined: for rw=0, sample cipo on the clk cycle of each of the last 8 SCLK rising edges, shift into rdata MSB first, and update rdata as a whole at DONE; writes SHALL leave rdata unchanged.
REQ-034 SHALL, without SPI_CTRL_READBACK_EN: tie rdata to 0x00, ignore cipo, and keep all other behaviour identical.

Verification
REQ-035 Bench SHALL cover write: DIV=4, rw=1, addr=0x02, wdata=0xA5 -> decoded bits 0x82A5; 16 rising edges; busy high for 137 cycles; one done pulse.
REQ-036 Bench SHALL cover read (macro on): rw=0, addr=0x04, slave drives 0x3C on cipo -> rdata=0x3C at the done cycle; with the macro off -> rdata=0x00.
REQ-037 Bench SHALL cover start held high through a frame -> exactly 2 frames with ncs high for 1 cycle between them; no third start accepted while busy.
REQ-038 Bench SHALL cover rst pulsed at SCLK edge 7 -> ncs=1 and sclk=0 the next cycle; no done pulse; busy=0.
REQ-039 Bench SHALL cover timing: DIV=2 -> sclk high and low phases each 2 cycles; ncs-low-to-first-rise = 4 cycles; last-fall-to-ncs-high = 2 cycles.
REQ-040 Bench SHALL cover wdata changed mid-frame from 0xA5 to 0xFF -> transmitted data remains 0xA5.
